fifo_uart_tx: RTL

Read-side consumer of the asynchronous FIFO. It runs in the FIFO read clock domain, pops one word whenever the FIFO is non-empty, and serializes it as a UART frame: start bit, data bits LSB first, optional parity, stop bit. Bit time is a programmable number of clock cycles. It drives the FIFO's rd_inc and is the only reader of the FIFO.

---
 rtl/fifo_uart_tx_pkg.sv | 20 ++
 rtl/fifo_uart_tx_if.sv | 21 ++
 rtl/fifo_uart_tx_baud_counter.sv | 36 +++
 rtl/fifo_uart_tx.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/fifo_uart_tx_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
// The frame FSM states and the parity-type encoding live here.
package fifo_uart_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    function automatic logic [7:0] eff_prescale8(input logic [7:0] p);
        return (p == 8'd0) ? 8'd1 : p;
    endfunction

endpackage

// File: rtl/fifo_uart_tx_if.sv
// Read-side FIFO port: empty flag, head word and pop strobe.
// master is the FIFO, slave is the single reader.
interface fifo_uart_tx_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_rd_data;
    logic                  fifo_rd_inc;

    modport master (
        output fifo_empty,
        output fifo_rd_data,
        input  fifo_rd_inc
    );

    modport slave (
        input  fifo_empty,
        input  fifo_rd_data,
        output fifo_rd_inc
    );
endinterface

// File: rtl/fifo_uart_tx_baud_counter.sv
// Bit-time counter: counts 0..P-1 and flags the last cycle of each bit.
// Cleared on every pop so a new frame always starts on a fresh bit.
module tx_baud_counter #(
    parameter int PRESCALE_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr,
    input  logic                      en,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic                      bit_last
);

    logic [PRESCALE_WIDTH-1:0] cnt_q;
    logic [PRESCALE_WIDTH-1:0] cnt_d;

    assign bit_last = (cnt_q == prescale - PRESCALE_WIDTH'(1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = bit_last ? '0 : cnt_q + PRESCALE_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// UART frame serializer fed directly from the read side of a FIFO.
// Pops a word when idle or at the end of a stop bit, then shifts it out.
module fifo_uart_tx
    import fifo_uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    fifo_uart_tx_if.slave             fifo,
    input  logic                      par_en,
    input  logic                      par_typ,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic                      tx_out,
    output logic                      busy
);

    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

    tx_state_e                 state_q;
    tx_state_e                 state_d;
    logic [BIT_W-1:0]          bit_q;
    logic [BIT_W-1:0]          bit_d;
    logic [DATA_WIDTH-1:0]     data_q;
    logic [DATA_WIDTH-1:0]     data_d;
    logic                      par_bit_q;
    logic                      par_bit_d;
    logic                      par_en_q;
    logic                      par_en_d;
    logic [PRESCALE_WIDTH-1:0] pre_q;
    logic [PRESCALE_WIDTH-1:0] pre_d;
    logic                      tx_q;
    logic                      tx_d;
    logic                      busy_q;
    logic                      busy_d;

    logic pop;
    logic bit_last;
    logic cnt_en;

    // A pop is only legal at a frame boundary and never under reset.
    assign pop = ((state_q == ST_IDLE) ||
                  ((state_q == ST_STOP) && bit_last)) &&
                 !fifo.fifo_empty && !rst;

    assign fifo.fifo_rd_inc = pop;
    assign cnt_en = (state_q != ST_IDLE);

    tx_baud_counter #(
        .PRESCALE_WIDTH(PRESCALE_WIDTH)
    ) u_baud (
        .clk      (clk),
        .rst      (rst),
        .clr      (pop),
        .en       (cnt_en),
        .prescale (pre_q),
        .bit_last (bit_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            bit_q     <= '0;
            data_q    <= '0;
            par_bit_q <= 1'b0;
            par_en_q  <= 1'b0;
            pre_q     <= PRESCALE_WIDTH'(1);
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_q     <= bit_d;
            data_q    <= data_d;
            par_bit_q <= par_bit_d;
            par_en_q  <= par_en_d;
            pre_q     <= pre_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_d     = bit_q;
        data_d    = data_q;
        par_bit_d = par_bit_q;
        par_en_d  = par_en_q;
        pre_d     = pre_q;

        if (pop) begin
            data_d    = fifo.fifo_rd_data;
            par_bit_d = (^fifo.fifo_rd_data) ^ (par_typ == PAR_ODD);
            par_en_d  = par_en;
            pre_d     = (prescale == '0) ? PRESCALE_WIDTH'(1) : prescale;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (bit_last) begin
                    state_d = ST_DATA;
                    bit_d   = '0;
                end
            end
            ST_DATA: begin
                if (bit_last) begin
                    if (bit_q == LAST_BIT) begin
                        state_d = par_en_q ? ST_PARITY : ST_STOP;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (bit_last) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_last) begin
                    state_d = pop ? ST_START : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Line level is registered from the next state so it lines up with it.
    always_comb begin
        tx_d   = 1'b1;
        busy_d = (state_d != ST_IDLE);
        unique case (state_d)
            ST_IDLE:   tx_d = 1'b1;
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = data_d[bit_d];
            ST_PARITY: tx_d = par_bit_d;
            ST_STOP:   tx_d = 1'b1;
            default:   tx_d = 1'b1;
        endcase
    end

    assign tx_out = tx_q;
    assign busy   = busy_q;

endmodule
